// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared widths and fetch-state encoding for the instruction
//            fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int ADDR_W      = 64;
    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_slot.sv
`default_nettype none
// ============================================================================
// Module   : fetch_slot
// Brief    : IF/ID output register. Holds one instruction and its PC and
//            presents it to decode over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_slot
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc;

    // Flush beats load; otherwise a load refills, and an accepted slot empties.
    // Data only changes on load, so it stays stable while the slot stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_instr <= in_instr;
            r_pc    <= in_pc;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_instr = r_instr;
    assign out_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_ctrl
// Brief    : Fetch sequencer for a combinational instruction ROM. Owns the PC,
//            the RUN/HALTED/FAULT state machine and the accepted-fetch counter.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                MEM_SIZE = 1024,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'd0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_req,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               fault,
    output logic [31:0]        fetch_count
);

    // Highest legal word address; comparing against it avoids pc+3 overflow.
    localparam logic [ADDR_W-1:0] C_LAST_PC = ADDR_W'(MEM_SIZE - INSTR_BYTES);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [31:0]       r_count;
    logic              w_load;
    logic              w_flush;
    logic              w_slot_free;
    logic              w_legal;
    logic              w_fire;

    assign w_slot_free = !out_valid || out_ready;
    assign w_legal     = (r_pc[1:0] == 2'b00) && (r_pc <= C_LAST_PC);
    assign w_fire      = out_valid && out_ready;

    // State and PC registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Next state, next PC and slot controls; redirect outranks halt and fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            RUN: begin
                if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                    w_flush  = 1'b1;
                    if (halt_req) begin
                        w_state_nxt = HALTED;
                    end
                end else if (halt_req) begin
                    // Slot is left alone so it can still drain to decode.
                    w_state_nxt = HALTED;
                end else if (w_slot_free) begin
                    if (w_legal) begin
                        w_load   = 1'b1;
                        w_pc_nxt = r_pc + ADDR_W'(INSTR_BYTES);
                    end else begin
                        w_state_nxt = FAULT;
                        w_flush     = 1'b1;
                    end
                end
            end
            HALTED: begin
                if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                    w_flush  = 1'b1;
                    if (!halt_req) begin
                        w_state_nxt = RUN;
                    end
                end
            end
            FAULT: begin
                // Terminal until reset.
            end
            default: begin
                w_state_nxt = FAULT;
                w_flush     = 1'b1;
            end
        endcase
    end

    // Count instructions handed to decode; wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_fire) begin
            r_count <= r_count + 32'd1;
        end
    end

    fetch_slot u_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .flush     (w_flush),
        .in_instr  (imem_instr),
        .in_pc     (r_pc),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc)
    );

    assign imem_addr   = r_pc;
    assign fault       = (r_state == FAULT);
    assign fetch_count = r_count;

endmodule
`default_nettype wire
